// File: rtl/wide_add_sequencer.sv
// Loads two 120-bit operands plus carry-in from a 16-bit stream, holds them for the ripple adder,
// then streams the captured {carry, sum} back out as 16-bit beats.
//
//   state       | meaning
//   LOAD_A      | accepting operand A beats, carry-in on beat 0
//   LOAD_B      | accepting operand B beats
//   SETTLE_WAIT | operands held while the ripple chain settles
//   DRAIN       | emitting result beats
module wide_add_sequencer #(
  parameter int WORD_W = 16,
  parameter int OP_W   = 120,
  parameter int BEATS  = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_cin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_cin,
  input  logic [OP_W-1:0]   add_sum,
  input  logic              add_carry,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int PAD_W = WORD_W * BEATS;
  localparam int BW    = $clog2(BEATS);
  localparam int SCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE_WAIT, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat, beat_inc;
  logic [SCW-1:0]  scnt;
  logic [OP_W:0]   result;
  logic            last_beat, settle_done, in_fire, out_fire;
  logic [PAD_W-1:0] a_wide, b_wide, res_wide;
  logic [BW+3:0]   word_base;

  assign last_beat   = (beat == BW'(BEATS - 1));
  assign beat_inc    = last_beat ? '0 : beat + 1'b1;
  assign settle_done = (scnt == SCW'(SETTLE - 1));
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign busy        = (state != LOAD_A) || (beat != '0);

  // Word width is fixed at 16, so the beat index times 16 is a 4-bit shift.
  assign word_base = {beat, 4'b0000};

  // Padding to a whole number of words lets the last, partial beat drop its upper byte naturally.
  always_comb begin
    a_wide = {{(PAD_W - OP_W){1'b0}}, op_a};
    b_wide = {{(PAD_W - OP_W){1'b0}}, op_b};
    a_wide[word_base +: WORD_W] = in_data;
    b_wide[word_base +: WORD_W] = in_data;
    res_wide = {{(PAD_W - OP_W - 1){1'b0}}, result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      LOAD_A: begin
        in_ready = rst_n;
        if (in_valid && last_beat) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = rst_n;
        if (in_valid && last_beat) state_nxt = SETTLE_WAIT;
      end
      SETTLE_WAIT: begin
        if (settle_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        out_data  = res_wide[word_base +: WORD_W];
        if (out_ready && last_beat) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat   <= '0;
      scnt   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        LOAD_A: if (in_fire) begin
          op_a <= a_wide[OP_W-1:0];
          if (beat == '0) op_cin <= in_cin;
          beat <= beat_inc;
        end
        LOAD_B: if (in_fire) begin
          op_b <= b_wide[OP_W-1:0];
          beat <= beat_inc;
          scnt <= '0;
        end
        SETTLE_WAIT: begin
          if (settle_done) begin
            result <= {add_carry, add_sum};
            scnt   <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        DRAIN: if (out_fire) beat <= beat_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: an ideal adder closes the loop, expected result
// beats are queued from the stimulus operands and checked by an independent output monitor.
module tb_wide_add_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_cin = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [119:0] op_a, op_b;
  logic         op_cin;
  logic [119:0] add_sum;
  logic         add_carry;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          beats_seen = 0;
  logic        stall_en = 1'b0;
  int          stall_left = 0;
  logic        rand_ready = 1'b0;

  wide_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_cin(in_cin), .in_valid(in_valid),
    .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .add_sum(add_sum),
    .add_carry(add_carry), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  // Ideal combinational adder standing in for the real ripple datapath.
  assign {add_carry, add_sum} = {1'b0, op_a} + {1'b0, op_b} + {120'b0, op_cin};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Output monitor: stability under stall, no input acceptance while draining, scoreboard pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 128'(out_valid), 128'd1);
        check("stall_data", 128'(out_data), 128'(prev_data));
        check("stall_last", 128'(out_last), 128'(prev_last));
      end
      if (out_valid) check("in_ready_drain", 128'(in_ready), 128'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want no beat at %0t", out_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 128'(out_data), 128'(mon_e.data));
          check("out_last", 128'(out_last), 128'(mon_e.last));
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #2;
    if (stall_en && out_valid && (beats_seen % 8) == 3 && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic send(input logic [15:0] d, input logic c, input int max_gap);
    int g;
    int t;
    g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_data  = d;
    in_cin   = c;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got 0 want 1 at %0t", $time);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Reference: result = A + B + cin on the low 120 bits of each raw operand, emitted LSW first.
  task automatic run_op(input logic [127:0] raw_a, input logic [127:0] raw_b, input logic cin,
                        input int gap);
    logic [119:0] a, b;
    logic [120:0] r;
    logic [127:0] w, sa, sb;
    int t;
    a = raw_a[119:0];
    b = raw_b[119:0];
    r = {1'b0, a} + {1'b0, b} + {120'b0, cin};
    w = {7'b0, r};
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{data: w[15:0], last: (k == 7)});
      w = w >> 16;
    end
    sa = raw_a;
    for (int k = 0; k < 8; k++) begin
      send(sa[15:0], (k == 0) ? cin : 1'($urandom_range(0, 1)), gap);
      sa = sa >> 16;
    end
    sb = raw_b;
    for (int k = 0; k < 8; k++) begin
      send(sb[15:0], 1'($urandom_range(0, 1)), gap);
      sb = sb >> 16;
    end
    @(negedge clk);
    check("settle_op_a", 128'(op_a), 128'(a));
    check("settle_op_b", 128'(op_b), 128'(b));
    check("settle_op_cin", 128'(op_cin), 128'(cin));
    check("settle_in_ready", 128'(in_ready), 128'd0);
    check("settle_busy", 128'(busy), 128'd1);
    check("settle_out_valid", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("settle2_op_cin", 128'(op_cin), 128'(cin));
    check("settle2_out_valid", 128'(out_valid), 128'd0);
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_busy", 128'(busy), 128'd0);
    check("idle_out_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    logic [127:0] ra, rb;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_op_a", 128'(op_a), 128'd0);
    check("rst_op_cin", 128'(op_cin), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    check("post_rst_out_valid", 128'(out_valid), 128'd0);
    check("post_rst_out_last", 128'(out_last), 128'd0);
    check("post_rst_out_data", 128'(out_data), 128'd0);
    check("post_rst_busy", 128'(busy), 128'd0);

    run_op(128'd1, 128'd1, 1'b0, 0);
    run_op({8'h00, {120{1'b1}}}, 128'd1, 1'b0, 0);
    run_op(128'd0, 128'd0, 1'b1, 0);
    ra = 128'hAB12;
    ra = ra << 112;
    run_op(ra, ra, 1'b0, 0);

    stall_en = 1'b1;
    stall_left = 3;
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_op(ra, rb, 1'b1, 3);
    stall_en = 1'b0;
    check("stall_consumed", 128'(stall_left), 128'd0);

    for (int k = 0; k < 5; k++) send(16'($urandom), 1'b1, 1);
    @(negedge clk);
    check("partial_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(in_ready), 128'd0);
    check("abort_op_a", 128'(op_a), 128'd0);
    check("abort_busy", 128'(busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(128'd2, 128'd3, 1'b0, 0);

    rand_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_op(ra, rb, 1'($urandom_range(0, 1)), 2);
    end
    rand_ready = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
